// File: rtl/phys_regfile_mp.sv
// phys_regfile_mp: multi-ported physical register file with per-register ready bits.
// Optional same-cycle write-to-read forwarding is enabled by defining PHYS_REGFILE_MP_BYPASS_EN.
`default_nettype none

module phys_regfile_mp #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_WR        = 5,
  parameter int NUM_RD        = 10,
  parameter int NUM_ALLOC     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_WR-1:0]                    wr_en,
  input  logic [NUM_WR*PHYS_REG_BITS-1:0]      wr_preg,
  input  logic [NUM_WR*32-1:0]                 wr_data,
  input  logic [NUM_RD*PHYS_REG_BITS-1:0]      rd_preg,
  output logic [NUM_RD*32-1:0]                 rd_data,
  output logic [NUM_RD-1:0]                    rd_ready,
  input  logic [NUM_ALLOC-1:0]                 alloc_en,
  input  logic [NUM_ALLOC*PHYS_REG_BITS-1:0]   alloc_preg,
  input  logic                                 flush,
  output logic                                 wr_conflict
);

  localparam int NUM_PREG = 2 ** PHYS_REG_BITS;

  logic [31:0]              r_data [NUM_PREG];
  logic [NUM_PREG-1:0]      r_ready;
  logic                     r_wr_conflict;

  logic [31:0]              w_data_nxt [NUM_PREG];
  logic [NUM_PREG-1:0]      w_ready_nxt;
  logic                     w_conflict;

  logic [PHYS_REG_BITS-1:0] w_wr_preg    [NUM_WR];
  logic [31:0]              w_wr_data    [NUM_WR];
  logic [PHYS_REG_BITS-1:0] w_alloc_preg [NUM_ALLOC];

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_unpack
    assign w_wr_preg[i] = wr_preg[i*PHYS_REG_BITS +: PHYS_REG_BITS];
    assign w_wr_data[i] = wr_data[i*32 +: 32];
  end

  for (genvar j = 0; j < NUM_ALLOC; j++) begin : g_alloc_unpack
    assign w_alloc_preg[j] = alloc_preg[j*PHYS_REG_BITS +: PHYS_REG_BITS];
  end

  // Ports are applied highest-first so the lowest-index writer lands last and wins.
  always_comb begin
    for (int e = 0; e < NUM_PREG; e++) begin
      w_data_nxt[e] = r_data[e];
    end
    w_ready_nxt = r_ready;
    for (int i = NUM_WR - 1; i >= 0; i--) begin
      if (wr_en[i] && (w_wr_preg[i] != '0)) begin
        w_data_nxt[w_wr_preg[i]]  = w_wr_data[i];
        w_ready_nxt[w_wr_preg[i]] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_ALLOC; j++) begin
      if (alloc_en[j] && (w_alloc_preg[j] != '0)) begin
        w_ready_nxt[w_alloc_preg[j]] = 1'b0;
      end
    end
    if (flush) begin
      w_ready_nxt = '1;
    end
    w_ready_nxt[0] = 1'b1;
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] && (w_wr_preg[i] == w_wr_preg[j]) &&
            (w_wr_preg[i] != '0)) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_PREG; e++) begin
        r_data[e] <= '0;
      end
      r_ready       <= '1;
      r_wr_conflict <= 1'b0;
    end else begin
      for (int e = 0; e < NUM_PREG; e++) begin
        r_data[e] <= w_data_nxt[e];
      end
      r_ready       <= w_ready_nxt;
      r_wr_conflict <= w_conflict;
    end
  end

  assign wr_conflict = r_wr_conflict;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [PHYS_REG_BITS-1:0] w_rp;
    logic [31:0]              w_rd;
    logic                     w_rr;

    assign w_rp = rd_preg[k*PHYS_REG_BITS +: PHYS_REG_BITS];

    always_comb begin
      w_rd = r_data[w_rp];
      w_rr = r_ready[w_rp];
`ifdef PHYS_REGFILE_MP_BYPASS_EN
      for (int i = NUM_WR - 1; i >= 0; i--) begin
        if (wr_en[i] && (w_wr_preg[i] == w_rp)) begin
          w_rd = w_wr_data[i];
          w_rr = 1'b1;
        end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (alloc_en[j] && (w_alloc_preg[j] == w_rp)) begin
          w_rr = 1'b0;
        end
      end
`endif
      // preg 0 and the reset window always read as a ready zero.
      if (!rst_n || (w_rp == '0)) begin
        w_rd = '0;
        w_rr = 1'b1;
      end
    end

    assign rd_data[k*32 +: 32] = w_rd;
    assign rd_ready[k]         = w_rr;
  end

endmodule

`default_nettype wire
